// File: rtl/imem_pkg.sv
// Shared types and helpers for the pipelined instruction memory.
// Error codes are OR-able: a fetch can be both out of range and misaligned.
package imem_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OOR  = 2'b01;
    localparam logic [1:0] ERR_MIS  = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
        logic [1:0]        err;
    } imem_rsp_t;

    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return 30'(addr >> 2);
    endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTHx32 word storage with a registered read port and an independent write port.
// Reads see the contents before any write on the same edge; out-of-range indices read 0 and never write.
module imem_array
    import imem_pkg::*;
#(
    parameter int IDX_W = 12,
    parameter int DEPTH = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_data
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_data_q;
    logic [WORD_W-1:0] rd_data_d;
    logic              rd_in_range;
    logic              wr_in_range;

    always_comb begin
        rd_in_range = 32'(rd_idx) < 32'(DEPTH);
        wr_in_range = 32'(wr_idx) < 32'(DEPTH);
        rd_data_d   = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_in_range ? mem[rd_idx[MEM_AW-1:0]] : '0;
        end
    end

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_idx[MEM_AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_pipe.sv
// Pipelined instruction memory: valid/ready fetch, LATENCY stages with a global stall,
// flush of in-flight fetches, range/alignment error flags and a run-time word-write port.
module imem_pipe
    import imem_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [1:0]        rsp_err,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [ADDR_W-3:0] wr_addr,
    input  logic [31:0]       wr_data
);

    localparam int IDX_W = ADDR_W - 2;

    if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
        $error("imem_pipe: LATENCY must be 1..3");
    end
    if (DEPTH > (1 << IDX_W)) begin : g_bad_depth
        $error("imem_pipe: DEPTH exceeds the address space");
    end

    logic              stall;
    logic              advance;
    logic [29:0]       word_full;
    logic [IDX_W-1:0]  req_idx;
    logic              req_oor;
    logic              req_mis;
    logic [1:0]        req_err;
    logic [WORD_W-1:0] rd_data;

    logic              vld_s  [LATENCY];
    logic [WORD_W-1:0] data_s [LATENCY];
    logic [1:0]        err_s  [LATENCY];

    always_comb begin
        word_full = word_index(32'(req_addr));
        req_idx   = word_full[IDX_W-1:0];
        req_oor   = word_full >= 30'(DEPTH);
        req_mis   = req_addr[1:0] != 2'b00;
        req_err   = (req_oor ? ERR_OOR : ERR_NONE) | (req_mis ? ERR_MIS : ERR_NONE);
    end

    // One stall signal freezes every stage, the read register and the request port together.
    assign stall     = vld_s[LATENCY-1] & ~rsp_ready;
    assign advance   = ~stall;
    assign req_ready = advance;

    imem_array #(
        .IDX_W (IDX_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (advance),
        .rd_idx  (req_idx),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_idx  (wr_addr),
        .wr_data (wr_data)
    );

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Stage 1 data lives in the array's read register; only valid and err are held here.
            logic       vld_q;
            logic       vld_d;
            logic [1:0] err_q;
            logic [1:0] err_d;

            always_comb begin
                vld_d = vld_q;
                err_d = err_q;
                if (advance) begin
                    vld_d = req_valid;
                    err_d = req_err;
                end
                if (flush) begin
                    vld_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    err_q <= ERR_NONE;
                end else begin
                    vld_q <= vld_d;
                    err_q <= err_d;
                end
            end

            assign vld_s[k]  = vld_q;
            assign err_s[k]  = err_q;
            assign data_s[k] = (err_q == ERR_NONE) ? rd_data : '0;
        end else begin : g_next
            imem_rsp_t stg_q;
            imem_rsp_t stg_d;

            always_comb begin
                stg_d = stg_q;
                if (advance) begin
                    stg_d = '{valid: vld_s[k-1], data: data_s[k-1], err: err_s[k-1]};
                end
                if (flush) begin
                    stg_d.valid = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stg_q <= '0;
                end else begin
                    stg_q <= stg_d;
                end
            end

            assign vld_s[k]  = stg_q.valid;
            assign data_s[k] = stg_q.data;
            assign err_s[k]  = stg_q.err;
        end
    end

    assign rsp_valid = vld_s[LATENCY-1];
    assign rsp_data  = data_s[LATENCY-1];
    assign rsp_err   = err_s[LATENCY-1];

endmodule

// File: tb/tb_imem_pipe.sv
// Bench for imem_pipe: three instances (LATENCY 1/2/3) share request and write stimulus,
// each with its own rsp_ready and scoreboard queue; scenario tasks add cycle-exact checks.
module tb_imem_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [13:0] req_addr;
    logic        flush;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;

    logic        rr [3];
    logic        qy [3];
    logic        rv [3];
    logic [31:0] rd [3];
    logic [1:0]  re [3];

    int          nchk = 0;
    int          nbad = 0;
    int          rcv [3];
    int          depth [3];
    logic [33:0] sbq [3][$];
    logic [31:0] shd [4096];

    always #5 clk = ~clk;

    imem_pipe #(.ADDR_W(14), .DEPTH(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(qy[0]), .req_addr(req_addr),
        .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_data(rd[0]), .rsp_err(re[0]), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    imem_pipe #(.ADDR_W(14), .DEPTH(4096), .LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(qy[1]), .req_addr(req_addr),
        .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_data(rd[1]), .rsp_err(re[1]), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    imem_pipe #(.ADDR_W(14), .DEPTH(4096), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(qy[2]), .req_addr(req_addr),
        .rsp_valid(rv[2]), .rsp_ready(rr[2]), .rsp_data(rd[2]), .rsp_err(re[2]), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    // Scoreboard: pop/compare transfers, then drop on flush, then push accepted fetches,
    // then apply the write so a same-cycle fetch sees the old word.
    always @(negedge clk) begin : mon
        logic [33:0] ex;
        logic [11:0] ix;
        logic [1:0]  ee;
        logic [31:0] dd;
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) sbq[d].delete();
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (rv[d] && rr[d]) begin
                    nchk++;
                    if (sbq[d].size() == 0) begin
                        nbad++;
                        $display("FAIL sb_extra dut%0d got d=%h e=%b, required no response", d, rd[d], re[d]);
                    end else begin
                        ex = sbq[d].pop_front();
                        rcv[d]++;
                        if ({re[d], rd[d]} !== ex) begin
                            nbad++;
                            $display("FAIL sb_data dut%0d got d=%h e=%b, required d=%h e=%b",
                                     d, rd[d], re[d], ex[31:0], ex[33:32]);
                        end
                    end
                end
                if (flush) begin
                    sbq[d].delete();
                end else if (req_valid && qy[d]) begin
                    ix    = req_addr[13:2];
                    ee[0] = int'(ix) >= depth[d];
                    ee[1] = req_addr[1:0] != 2'b00;
                    dd    = (ee != 2'b00) ? 32'h0 : shd[ix];
                    sbq[d].push_back({ee, dd});
                end
            end
            if (wr_en) shd[wr_addr] = wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] v);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = v;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            nchk++;
            if (rv[d] !== 1'b0 || rd[d] !== 32'h0 || re[d] !== 2'b00) begin
                nbad++;
                $display("FAIL reset_out dut%0d got v=%b d=%h e=%b, required v=0 d=0 e=00", d, rv[d], rd[d], re[d]);
            end
        end
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) begin
            nchk++;
            if (qy[d] !== 1'b1 || rv[d] !== 1'b0) begin
                nbad++;
                $display("FAIL reset_ready dut%0d got ready=%b v=%b, required ready=1 v=0", d, qy[d], rv[d]);
            end
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 4096; i++) wr(12'(i), 32'h0);
    endtask

    task automatic test_basic();
        wr(12'd0, 32'h800000b7);
        wr(12'd1, 32'h00000113);
        req_valid = 1'b1;
        req_addr  = 14'h0000;
        tick();
        nchk++;
        if (rv[0] !== 1'b1 || rd[0] !== 32'h800000b7 || re[0] !== 2'b00) begin
            nbad++;
            $display("FAIL basic_w0 got v=%b d=%h e=%b, required v=1 d=800000b7 e=00", rv[0], rd[0], re[0]);
        end
        req_addr = 14'h0004;
        tick();
        nchk++;
        if (rv[0] !== 1'b1 || rd[0] !== 32'h00000113 || re[0] !== 2'b00) begin
            nbad++;
            $display("FAIL basic_w1 got v=%b d=%h e=%b, required v=1 d=00000113 e=00", rv[0], rd[0], re[0]);
        end
        req_valid = 1'b0;
        tick();
        nchk++;
        if (rv[0] !== 1'b0) begin
            nbad++;
            $display("FAIL basic_idle got v=%b, required v=0", rv[0]);
        end
        tick();
        tick();
    endtask

    task automatic test_errors();
        logic [13:0] addrs [4];
        logic [31:0] xd [4];
        logic [1:0]  xe [4];
        addrs = '{14'h3FFC, 14'h0006, 14'h3FFE, 14'h0FFC};
        xd    = '{32'h0, 32'h0, 32'h0, 32'h12345678};
        xe    = '{2'b01, 2'b10, 2'b11, 2'b00};
        wr(12'd1023, 32'h12345678);
        wr(12'd4095, 32'hdeadbeef);
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = addrs[i];
            tick();
            nchk++;
            if (rv[0] !== 1'b1 || rd[0] !== xd[i] || re[0] !== xe[i]) begin
                nbad++;
                $display("FAIL err_%0d addr=%h got v=%b d=%h e=%b, required v=1 d=%h e=%b",
                         i, addrs[i], rv[0], rd[0], re[0], xd[i], xe[i]);
            end
        end
        req_valid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_rbw();
        wr(12'd5, 32'h00000013);
        wr_en     = 1'b1;
        wr_addr   = 12'd5;
        wr_data   = 32'hc0001073;
        req_valid = 1'b1;
        req_addr  = 14'h0014;
        tick();
        wr_en = 1'b0;
        nchk++;
        if (rd[0] !== 32'h00000013) begin
            nbad++;
            $display("FAIL rbw_old got d=%h, required d=00000013", rd[0]);
        end
        tick();
        nchk++;
        if (rd[0] !== 32'hc0001073) begin
            nbad++;
            $display("FAIL rbw_new got d=%h, required d=c0001073", rd[0]);
        end
        req_valid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_stall();
        int base;
        wr(12'd8,  32'h00a00093);
        wr(12'd9,  32'h00b00113);
        wr(12'd10, 32'h00c00193);
        rr[2] = 1'b0;
        base  = rcv[2];
        req_valid = 1'b1;
        req_addr  = 14'h0020;
        tick();
        req_addr  = 14'h0024;
        tick();
        req_addr  = 14'h0028;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            nchk++;
            if (qy[2] !== 1'b0) begin
                nbad++;
                $display("FAIL stall_ready cyc%0d got ready=%b, required 0", c, qy[2]);
            end
            nchk++;
            if (rv[2] !== 1'b1 || rd[2] !== 32'h00a00093 || re[2] !== 2'b00) begin
                nbad++;
                $display("FAIL stall_hold cyc%0d got v=%b d=%h e=%b, required v=1 d=00a00093 e=00",
                         c, rv[2], rd[2], re[2]);
            end
            tick();
        end
        rr[2] = 1'b1;
        for (int c = 0; c < 10 && (rcv[2] - base) < 3; c++) tick();
        tick();
        tick();
        nchk++;
        if (rcv[2] - base != 3) begin
            nbad++;
            $display("FAIL stall_count got %0d responses, required 3", rcv[2] - base);
        end
    endtask

    task automatic test_flush();
        wr(12'd12, 32'h00d00213);
        wr(12'd13, 32'h00e00293);
        wr(12'd14, 32'h00f00313);
        rr[1] = 1'b0;
        req_valid = 1'b1;
        req_addr  = 14'h0030;
        tick();
        req_addr  = 14'h0034;
        tick();
        nchk++;
        if (rv[1] !== 1'b1 || qy[1] !== 1'b0 || qy[0] !== 1'b1) begin
            nbad++;
            $display("FAIL flush_pre got v2=%b ready2=%b ready1=%b, required 1 0 1", rv[1], qy[1], qy[0]);
        end
        flush    = 1'b1;
        req_addr = 14'h0038;
        tick();
        nchk++;
        if (rv[1] !== 1'b0 || qy[1] !== 1'b1 || rv[0] !== 1'b0 || rv[2] !== 1'b0) begin
            nbad++;
            $display("FAIL flush_clear got v1=%b v2=%b v3=%b ready2=%b, required 0 0 0 1", rv[0], rv[1], rv[2], qy[1]);
        end
        flush = 1'b0;
        rr[1] = 1'b1;
        tick();
        req_valid = 1'b0;
        nchk++;
        if (rv[1] !== 1'b0) begin
            nbad++;
            $display("FAIL flush_gap got v=%b, required 0", rv[1]);
        end
        tick();
        nchk++;
        if (rv[1] !== 1'b1 || rd[1] !== 32'h00f00313 || re[1] !== 2'b00) begin
            nbad++;
            $display("FAIL flush_after got v=%b d=%h e=%b, required v=1 d=00f00313 e=00", rv[1], rd[1], re[1]);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1;
        req_addr  = 14'h0020;
        tick();
        req_addr  = 14'h0024;
        tick();
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            nchk++;
            if (rv[d] !== 1'b0 || rd[d] !== 32'h0 || re[d] !== 2'b00) begin
                nbad++;
                $display("FAIL rstmid_out dut%0d got v=%b d=%h e=%b, required v=0 d=0 e=00", d, rv[d], rd[d], re[d]);
            end
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                nchk++;
                if (rv[d] !== 1'b0) begin
                    nbad++;
                    $display("FAIL rstmid_quiet dut%0d cyc%0d got v=%b, required 0", d, c, rv[d]);
                end
            end
        end
    endtask

    task automatic test_drain();
        for (int c = 0; c < 20 && (sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0; c++) tick();
        for (int d = 0; d < 3; d++) begin
            nchk++;
            if (sbq[d].size() != 0) begin
                nbad++;
                $display("FAIL drain dut%0d got %0d outstanding, required 0", d, sbq[d].size());
            end
        end
    endtask

    initial begin
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        depth     = '{1024, 4096, 4096};
        for (int d = 0; d < 3; d++) begin
            rr[d]  = 1'b1;
            rcv[d] = 0;
        end
        for (int i = 0; i < 4096; i++) shd[i] = 32'h0;
        test_reset();
        preload();
        test_basic();
        test_errors();
        test_rbw();
        test_stall();
        test_flush();
        test_drain();
        test_reset_mid();
        test_drain();
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
